pit_multi: RTL

Parametrised programmable interval timer. It has CHANNELS independent down-counters of WIDTH bits, and each channel runs in one of four 8254-style modes (0–3). The block sits behind a synchronous chip-select/read/write register bus. Counting runs from per-channel tick strobes in a single clock domain, replacing the fixed three-channel, 8-bit-bus, multi-clock timer in the peripheral subsystem.

---
 rtl/pit_multi_if.sv | 15 +
 rtl/pit_multi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pit_multi_if.sv
// rtl/pit_multi_if.sv - chip-select/read/write register bus bundle for pit_multi
interface pit_multi_if #(
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 16
);
  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;

  modport master (output cs_n, wr_n, rd_n, addr, wdata, input rdata);
  modport slave  (input cs_n, wr_n, rd_n, addr, wdata, output rdata);
endinterface

// File: rtl/pit_multi.sv
// rtl/pit_multi.sv - CHANNELS x WIDTH programmable interval timer, 8254-style modes 0-3
// PIT_STATUS_EN adds a status readback at CTRL_ADDR for the last addressed channel.
module pit_multi #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pit_multi_if.slave          bus,
  input  logic [CHANNELS-1:0] tick,
  input  logic [CHANNELS-1:0] gate,
  output logic [CHANNELS-1:0] out
);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = {ADDR_W{1'b1}};
  localparam logic [WIDTH-1:0]  HALF_MAX  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] count_q  [CHANNELS];
  logic [WIDTH-1:0] count_d  [CHANNELS];
  logic [WIDTH-1:0] reload_q [CHANNELS];
  logic [WIDTH-1:0] reload_d [CHANNELS];
  logic [WIDTH-1:0] snap_q   [CHANNELS];
  logic [WIDTH-1:0] snap_d   [CHANNELS];
  logic [1:0]       mode_q   [CHANNELS];
  logic [1:0]       mode_d   [CHANNELS];
  logic [WIDTH-1:0] eff      [CHANNELS];
  logic [WIDTH-1:0] half_hi  [CHANNELS];
  logic [WIDTH-1:0] half_lo  [CHANNELS];

  logic [CHANNELS-1:0] snap_vld_q, snap_vld_d, null_q, null_d, idle_q, idle_d;
  logic [CHANNELS-1:0] pend_q, pend_d, run_q, run_d, out_q, out_d, gate_q, gate_re;
  logic [WIDTH-1:0]    rdata_q, rd_val;

  logic       wr_en, rd_en, ctrl_ok, ctrl_latch;
  logic [3:0] ctrl_ch;
  logic [1:0] ctrl_mode;

  assign wr_en      = ~bus.cs_n & ~bus.wr_n;
  assign rd_en      = ~bus.cs_n & ~bus.rd_n & bus.wr_n;
  assign ctrl_ch    = bus.wdata[7:4];
  assign ctrl_latch = bus.wdata[3];
  assign ctrl_mode  = bus.wdata[1:0];
  assign ctrl_ok    = wr_en && (bus.addr == CTRL_ADDR) && (ctrl_ch < 4'(CHANNELS));
  assign gate_re    = gate & ~gate_q;
  assign out        = out_q;
  assign bus.rdata  = rdata_q;

  // Effective period: 0 means 2**WIDTH, and 1 is promoted to 2 for modes 2/3.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eff[i]     = (reload_q[i] == WIDTH'(1)) ? WIDTH'(2) : reload_q[i];
      half_lo[i] = (eff[i] == '0) ? HALF_MAX : (eff[i] >> 1);
      half_hi[i] = (eff[i] == '0) ? HALF_MAX : (eff[i] >> 1) + WIDTH'(eff[i][0]);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      count_d[i]    = count_q[i];
      reload_d[i]   = reload_q[i];
      snap_d[i]     = snap_q[i];
      mode_d[i]     = mode_q[i];
      snap_vld_d[i] = snap_vld_q[i];
      null_d[i]     = null_q[i];
      idle_d[i]     = idle_q[i];
      pend_d[i]     = pend_q[i];
      run_d[i]      = run_q[i];
      out_d[i]      = out_q[i];

      if (ctrl_ok && ctrl_ch == 4'(i) && ctrl_latch && !snap_vld_q[i]) begin
        snap_d[i]     = count_q[i];
        snap_vld_d[i] = 1'b1;
      end
      if (rd_en && bus.addr == ADDR_W'(i) && snap_vld_q[i])
        snap_vld_d[i] = 1'b0;

      if (ctrl_ok && ctrl_ch == 4'(i) && !ctrl_latch) begin
        mode_d[i] = ctrl_mode;
        null_d[i] = 1'b1;
        idle_d[i] = 1'b1;
        pend_d[i] = 1'b0;
        run_d[i]  = 1'b0;
        out_d[i]  = (ctrl_mode != 2'd0);
      end else if (wr_en && bus.addr == ADDR_W'(i)) begin
        // Mode 1 waits for a gate rising edge before the reload is taken.
        reload_d[i] = bus.wdata;
        null_d[i]   = 1'b1;
        idle_d[i]   = 1'b0;
        pend_d[i]   = (mode_q[i] != 2'd1);
        if (mode_q[i] == 2'd0)
          out_d[i] = 1'b0;
      end else if (!idle_q[i]) begin
        if (mode_q[i][1] && !gate[i])
          out_d[i] = 1'b1;
        if (tick[i]) begin
          if (pend_q[i] && (!mode_q[i][1] || gate[i])) begin
            pend_d[i] = 1'b0;
            null_d[i] = 1'b0;
            run_d[i]  = 1'b1;
            case (mode_q[i])
              2'd0: count_d[i] = reload_q[i];
              2'd1: begin count_d[i] = reload_q[i]; out_d[i] = 1'b0; end
              2'd2: begin count_d[i] = eff[i];      out_d[i] = 1'b1; end
              default: begin count_d[i] = half_hi[i]; out_d[i] = 1'b1; end
            endcase
          end else if (run_q[i] && (mode_q[i] == 2'd1 || gate[i])) begin
            case (mode_q[i])
              2'd0: begin
                count_d[i] = count_q[i] - WIDTH'(1);
                if (count_q[i] == WIDTH'(1)) out_d[i] = 1'b1;
              end
              2'd1: begin
                count_d[i] = count_q[i] - WIDTH'(1);
                if (count_q[i] == WIDTH'(1)) begin
                  out_d[i] = 1'b1;
                  run_d[i] = 1'b0;
                end
              end
              2'd2: begin
                if (count_q[i] == WIDTH'(1)) begin
                  count_d[i] = eff[i];
                  out_d[i]   = 1'b1;
                end else begin
                  count_d[i] = count_q[i] - WIDTH'(1);
                  if (count_q[i] == WIDTH'(2)) out_d[i] = 1'b0;
                end
              end
              default: begin
                // Each half-period ends on the tick from 1 and reloads the other half.
                if (count_q[i] == WIDTH'(1)) begin
                  out_d[i]   = ~out_q[i];
                  count_d[i] = out_q[i] ? half_lo[i] : half_hi[i];
                end else begin
                  count_d[i] = count_q[i] - WIDTH'(1);
                end
              end
            endcase
          end
        end
        if (mode_q[i] != 2'd0 && gate_re[i])
          pend_d[i] = 1'b1;
      end
    end
  end

`ifdef PIT_STATUS_EN
  logic [3:0] stat_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stat_ch <= '0;
    else if (ctrl_ok)
      stat_ch <= ctrl_ch;
  end
`endif

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.addr == ADDR_W'(i))
        rd_val = snap_vld_q[i] ? snap_q[i] : count_q[i];
`ifdef PIT_STATUS_EN
      if (bus.addr == CTRL_ADDR && stat_ch == 4'(i))
        rd_val = WIDTH'({null_q[i], out_q[i], 1'b0, mode_q[i]});
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        snap_q[i]   <= '0;
        mode_q[i]   <= '0;
      end
      snap_vld_q <= '0;
      null_q     <= '0;
      idle_q     <= '1;
      pend_q     <= '0;
      run_q      <= '0;
      out_q      <= '0;
      gate_q     <= '0;
      rdata_q    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        snap_q[i]   <= snap_d[i];
        mode_q[i]   <= mode_d[i];
      end
      snap_vld_q <= snap_vld_d;
      null_q     <= null_d;
      idle_q     <= idle_d;
      pend_q     <= pend_d;
      run_q      <= run_d;
      out_q      <= out_d;
      gate_q     <= gate;
      if (rd_en)
        rdata_q <= rd_val;
    end
  end
endmodule
